// File: rtl/intt_seq_core.sv
// Sequential 16-point inverse NTT (Gentleman-Sande, one butterfly per cycle) over Z_q.
// Define INTT_SCALE_EN to multiply each output by N^-1 mod q (true inverse NTT).
module intt_seq_core #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MODULUS    = 17,
  parameter int ROOT       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  function automatic longint pow_mod(input longint a, input longint e);
    longint r;
    r = 64'sd1;
    for (longint i = 64'sd0; i < e; i++) begin
      r = (r * a) % MODULUS;
    end
    return r;
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Modulus is prime, so inverses follow from Fermat: a^(q-2).
  localparam longint ROOT_INV = pow_mod(longint'(ROOT % MODULUS), longint'(MODULUS - 2));

  localparam logic [DATA_WIDTH-1:0]   Q  = DATA_WIDTH'(MODULUS);
  localparam logic [DATA_WIDTH:0]     Q1 = (DATA_WIDTH+1)'(MODULUS);
  localparam logic [2*DATA_WIDTH-1:0] Q2 = (2*DATA_WIDTH)'(MODULUS);
  localparam logic [3:0]              LAST_IN   = 4'(N - 1);
  localparam logic [4:0]              LAST_CALC = 5'(2 * N - 1);
  localparam logic [4:0]              OUT_DONE  = 5'(N);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t                  state_r, state_s;
  logic [3:0]              load_idx_r;
  logic [4:0]              calc_cnt_r;
  logic [4:0]              rd_idx_r;
  logic                    in_ready_r, out_valid_r, busy_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic [DATA_WIDTH-1:0]   mem_r [16];

  logic                    in_hs_s, out_hs_s;
  logic [3:0]              i0_s, i1_s;
  logic [2:0]              e_s;
  logic [DATA_WIDTH-1:0]   u_s, v_s, tw_s, sum_s, dif_s, prod_s, load_s;
  logic [DATA_WIDTH-1:0]   rd_word_s, out_word_s;
  logic [DATA_WIDTH:0]     sum_w_s, dif_w_s;
  logic [2*DATA_WIDTH-1:0] mul_s;
  logic [DATA_WIDTH-1:0]   tw_tbl [8];

  // Twiddle exponents j*N/LEN never exceed 7, so eight powers of ROOT_INV suffice.
  for (genvar e = 0; e < 8; e++) begin : g_tw
    localparam logic [DATA_WIDTH-1:0] TW = DATA_WIDTH'(pow_mod(ROOT_INV, longint'(e)));
    assign tw_tbl[e] = TW;
  end

  assign in_hs_s   = in_valid & in_ready_r;
  assign out_hs_s  = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_LOAD: begin
        if (in_hs_s && (load_idx_r == LAST_IN)) state_s = S_CALC;
        else state_s = S_LOAD;
      end
      S_CALC: begin
        if (calc_cnt_r == LAST_CALC) state_s = S_OUT;
        else state_s = S_CALC;
      end
      S_OUT: begin
        if (out_hs_s && (rd_idx_r == OUT_DONE)) state_s = S_LOAD;
        else state_s = S_OUT;
      end
      default: state_s = S_LOAD;
    endcase
  end

  // Butterfly index and twiddle decode: cnt[4:3] is the stage, cnt[2:0] the butterfly.
  always_comb begin
    i0_s = 4'd0;
    i1_s = 4'd0;
    e_s  = 3'd0;
    case (calc_cnt_r[4:3])
      2'd0: begin
        i0_s = {1'b0, calc_cnt_r[2:0]};
        i1_s = {1'b1, calc_cnt_r[2:0]};
        e_s  = calc_cnt_r[2:0];
      end
      2'd1: begin
        i0_s = {calc_cnt_r[2], 1'b0, calc_cnt_r[1:0]};
        i1_s = {calc_cnt_r[2], 1'b1, calc_cnt_r[1:0]};
        e_s  = {calc_cnt_r[1:0], 1'b0};
      end
      2'd2: begin
        i0_s = {calc_cnt_r[2:1], 1'b0, calc_cnt_r[0]};
        i1_s = {calc_cnt_r[2:1], 1'b1, calc_cnt_r[0]};
        e_s  = {calc_cnt_r[0], 2'b00};
      end
      default: begin
        i0_s = {calc_cnt_r[2:0], 1'b0};
        i1_s = {calc_cnt_r[2:0], 1'b1};
        e_s  = 3'd0;
      end
    endcase
  end

  // Butterfly arithmetic; operands are always < q so one conditional subtract reduces sums.
  always_comb begin
    u_s     = mem_r[i0_s];
    v_s     = mem_r[i1_s];
    tw_s    = tw_tbl[e_s];
    sum_w_s = {1'b0, u_s} + {1'b0, v_s};
    if (sum_w_s >= Q1) sum_s = DATA_WIDTH'(sum_w_s - Q1);
    else sum_s = DATA_WIDTH'(sum_w_s);
    dif_w_s = {1'b0, u_s} + Q1 - {1'b0, v_s};
    if (dif_w_s >= Q1) dif_s = DATA_WIDTH'(dif_w_s - Q1);
    else dif_s = DATA_WIDTH'(dif_w_s);
    mul_s   = {{DATA_WIDTH{1'b0}}, dif_s} * {{DATA_WIDTH{1'b0}}, tw_s};
    prod_s  = DATA_WIDTH'(mul_s % Q2);
    load_s  = in_data % Q;
  end

  assign rd_word_s = mem_r[bitrev4(rd_idx_r[3:0])];

`ifdef INTT_SCALE_EN
  localparam logic [2*DATA_WIDTH-1:0] N_INV =
    (2*DATA_WIDTH)'(pow_mod(longint'(N % MODULUS), longint'(MODULUS - 2)));
  logic [2*DATA_WIDTH-1:0] out_mul_s;
  // Output scaling by N^-1 mod q.
  always_comb begin
    out_mul_s  = {{DATA_WIDTH{1'b0}}, rd_word_s} * N_INV;
    out_word_s = DATA_WIDTH'(out_mul_s % Q2);
  end
`else
  assign out_word_s = rd_word_s;
`endif

  // Coefficient storage: loaded in S_LOAD, updated in place in S_CALC; no reset needed.
  always_ff @(posedge clk) begin
    if ((state_r == S_LOAD) && in_hs_s) begin
      mem_r[load_idx_r] <= load_s;
    end else if (state_r == S_CALC) begin
      mem_r[i0_s] <= sum_s;
      mem_r[i1_s] <= prod_s;
    end else begin
      mem_r[0] <= mem_r[0];
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_LOAD;
      load_idx_r  <= 4'd0;
      calc_cnt_r  <= 5'd0;
      rd_idx_r    <= 5'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == S_LOAD);
      busy_r     <= (state_s != S_LOAD);
      case (state_r)
        S_LOAD: begin
          if (in_hs_s) load_idx_r <= load_idx_r + 4'd1;
          else load_idx_r <= load_idx_r;
        end
        S_CALC: begin
          calc_cnt_r <= calc_cnt_r + 5'd1;
          rd_idx_r   <= 5'd0;
        end
        S_OUT: begin
          // Refill the output register whenever it is empty or being drained.
          if (!out_valid_r || out_ready) begin
            if (rd_idx_r != OUT_DONE) begin
              out_data_r  <= out_word_s;
              out_valid_r <= 1'b1;
              rd_idx_r    <= rd_idx_r + 5'd1;
            end else begin
              out_valid_r <= 1'b0;
            end
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intt_seq_core.sv
// Directed bench for intt_seq_core: a direct inverse-DFT model over Z_17 fills a scoreboard.
module tb_intt_seq_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];

  intt_seq_core #(.N(16), .DATA_WIDTH(16), .MODULUS(17), .ROOT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pw(input int a, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * a) % 17;
    return r;
  endfunction

  // x[n] = sum_k X[k] * 6^(k*n) mod 17, optionally scaled by 16 = 16^-1 mod 17.
  function automatic int model(input int d[16], input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < 16; k++) acc = (acc + (d[k] % 17) * pw(6, (k * n) % 16)) % 17;
`ifdef INTT_SCALE_EN
    acc = (acc * 16) % 17;
`endif
    return acc;
  endfunction

  task automatic send_block(input int d[16], input bit timing);
    int guard;
    int cyc;
    for (int n = 0; n < 16; n++) exp_q.push_back(model(d, n));
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = d[i][15:0];
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) check("in_ready_timeout", 32'(guard), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("in_ready_drop", 32'(in_ready), 32'd0);
    check("busy_calc", 32'(busy), 32'd1);
    if (timing) begin
      cyc = 0;
      while (!out_valid && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("latency", 32'(cyc), 32'd33);
    end
  endtask

  task automatic recv_block(input bit stall);
    int got;
    int cyc;
    int exp;
    bit stalled;
    logic [15:0] held;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = 16'd0;
    while (got < 16 && cyc < 400) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (stalled && out_valid) check("stall_hold", 32'(out_data), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("data[%0d]", got), 32'(out_data), 32'(exp));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("out_count", 32'(got), 32'd16);
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_rise", 32'(in_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int blk[16];

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // All ones: energy collapses into output 0.
    for (int i = 0; i < 16; i++) blk[i] = 1;
    send_block(blk, 1'b1);
    recv_block(1'b0);

    // Single impulse: flat output.
    for (int i = 0; i < 16; i++) blk[i] = (i == 0) ? 1 : 0;
    send_block(blk, 1'b1);
    recv_block(1'b0);

    // 18 reduces to 1 on input.
    for (int i = 0; i < 16; i++) blk[i] = 18;
    send_block(blk, 1'b1);
    recv_block(1'b0);

    // Random data under a 1,0,0 back-pressure pattern.
    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 65535));
    send_block(blk, 1'b1);
    recv_block(1'b1);

    // Reset during the 10th S_CALC cycle discards the block.
    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 16));
    send_block(blk, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_rise", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 65535));
    send_block(blk, 1'b1);
    recv_block(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
